// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if
//   Command channel of the counting-job sequencer. It carries one job
//   request per valid/ready handshake.
//   Signals:
//     cmd_valid   job request valid (caller -> sequencer)
//     cmd_ready   sequencer idle and able to take a job (sequencer -> caller)
//     cmd_start   first count value of each pass
//     cmd_end     terminal value of the first pass
//     cmd_mode    00 one-shot, 01 auto-reload, 10 ping-pong, 11 one-shot
//     cmd_repeat  extra passes after the first (ignored in one-shot)
//   Modports: master (job issuer), slave (counter_sequencer).
interface counter_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_end;
  logic [1:0]       cmd_mode;
  logic [REP_W-1:0] cmd_repeat;

  modport master (
    output cmd_valid,
    output cmd_start,
    output cmd_end,
    output cmd_mode,
    output cmd_repeat,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_start,
    input  cmd_end,
    input  cmd_mode,
    input  cmd_repeat,
    output cmd_ready
  );
endinterface

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Programmable up/down count engine that runs one counting job at a time.
//   A job (start, end, mode, repeat) is taken over the cmd interface; the
//   block then counts one step per cycle toward the target, emitting a tick
//   on every completed pass and a one-cycle done pulse per completed job.
//   Ports:
//     clk     clock, all state changes on its rising edge
//     reset   synchronous, active-high reset
//     cmd     job command channel (slave side), cmd_ready high only in IDLE
//     hold    freezes count and pass counter while high
//     abort   cancels the active job (back to IDLE, no done pulse)
//     count   current count value (registered)
//     dir     1 = counting up toward target, 0 = down (registered)
//     busy    high whenever the FSM is not IDLE
//     tick    combinational terminal-count indication while running
//     done    one-cycle pulse while the FSM is in DONE
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  counter_sequencer_if.slave  cmd,
  input  logic                hold,
  input  logic                abort,
  output logic [WIDTH-1:0]    count,
  output logic                dir,
  output logic                busy,
  output logic                tick,
  output logic                done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0]       MODE_RELOAD   = 2'b01;
  localparam logic [1:0]       MODE_PINGPONG = 2'b10;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [REP_W-1:0] REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] REP_ZERO = {REP_W{1'b0}};

  state_t           state_r,  state_s;
  logic [WIDTH-1:0] count_r,  count_s;
  logic [WIDTH-1:0] target_r, target_s;
  logic [WIDTH-1:0] start_r,  start_s;
  logic [WIDTH-1:0] end_r,    end_s;
  logic [1:0]       mode_r,   mode_s;
  logic [REP_W-1:0] passes_r, passes_s;
  logic             dir_r,    dir_s;
  logic             tick_s;
  logic             ready_s;
  logic             accept_s;
  logic             at_target_s;
  logic [WIDTH-1:0] pp_target_s;

  assign ready_s     = (state_r == ST_IDLE) && !reset;
  assign accept_s    = cmd.cmd_valid && ready_s;
  assign at_target_s = (count_r == target_r);
  // Ping-pong bounces between the latched end and start values.
  assign pp_target_s = (target_r == end_r) ? start_r : end_r;

  // Next-state and datapath decode; RUN priority is abort > hold > step > terminal.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    target_s = target_r;
    start_s  = start_r;
    end_s    = end_r;
    mode_s   = mode_r;
    passes_s = passes_r;
    dir_s    = dir_r;
    tick_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          start_s  = cmd.cmd_start;
          end_s    = cmd.cmd_end;
          mode_s   = cmd.cmd_mode;
          count_s  = cmd.cmd_start;
          target_s = cmd.cmd_end;
          dir_s    = (cmd.cmd_end >= cmd.cmd_start);
          state_s  = ST_RUN;
          if ((cmd.cmd_mode == MODE_RELOAD) || (cmd.cmd_mode == MODE_PINGPONG)) begin
            passes_s = cmd.cmd_repeat;
          end else begin
            passes_s = REP_ZERO;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (hold) begin
          state_s = ST_RUN;
        end else if (!at_target_s) begin
          // Direction always points at the target, so this never wraps.
          if (dir_r) begin
            count_s = count_r + CNT_ONE;
          end else begin
            count_s = count_r - CNT_ONE;
          end
        end else if (passes_r == REP_ZERO) begin
          tick_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          tick_s   = 1'b1;
          passes_s = passes_r - REP_ONE;
          case (mode_r)
            MODE_RELOAD: begin
              count_s = start_r;
            end
            MODE_PINGPONG: begin
              target_s = pp_target_s;
              dir_s    = ~dir_r;
              // First step of the return leg happens on the turning edge.
              if (pp_target_s > count_r) begin
                count_s = count_r + CNT_ONE;
              end else if (pp_target_s < count_r) begin
                count_s = count_r - CNT_ONE;
              end else begin
                count_s = count_r;
              end
            end
            default: begin
              state_s = ST_DONE;
            end
          endcase
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      count_r  <= CNT_ZERO;
      target_r <= CNT_ZERO;
      start_r  <= CNT_ZERO;
      end_r    <= CNT_ZERO;
      mode_r   <= 2'b00;
      passes_r <= REP_ZERO;
      dir_r    <= 1'b1;
    end else begin
      state_r  <= state_s;
      count_r  <= count_s;
      target_r <= target_s;
      start_r  <= start_s;
      end_r    <= end_s;
      mode_r   <= mode_s;
      passes_r <= passes_s;
      dir_r    <= dir_s;
    end
  end

  assign cmd.cmd_ready = ready_s;
  assign count         = count_r;
  assign dir           = dir_r;
  assign busy          = (state_r != ST_IDLE) && !reset;
  assign done          = (state_r == ST_DONE) && !reset;
  assign tick          = tick_s && !reset;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer
//   Self-checking bench for counter_sequencer: a table of per-cycle
//   {inputs, expected outputs} records plus hand-written sequences for
//   hold, abort and reset corner cases.
module tb_counter_sequencer;

  logic       clk;
  logic       reset;
  logic       hold;
  logic       abort;
  logic [7:0] count;
  logic       dir;
  logic       busy;
  logic       tick;
  logic       done;

  int total;
  int bad;

  counter_sequencer_if #(.WIDTH(8), .REP_W(4)) cif ();

  counter_sequencer #(.WIDTH(8), .REP_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cif),
    .hold  (hold),
    .abort (abort),
    .count (count),
    .dir   (dir),
    .busy  (busy),
    .tick  (tick),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [7:0] s;
    logic [7:0] e;
    logic [1:0] m;
    logic [3:0] r;
    logic       h;
    logic       a;
    logic [7:0] cnt;
    logic       d;
    logic       b;
    logic       t;
    logic       dn;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [7:0] s, input logic [7:0] e,
                     input logic [1:0] m, input logic [3:0] r, input logic h,
                     input logic a, input logic [7:0] cnt, input logic d,
                     input logic b, input logic t, input logic dn, input logic rdy);
    vecs.push_back('{v, s, e, m, r, h, a, cnt, d, b, t, dn, rdy});
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive_cmd(input logic v, input logic [7:0] s, input logic [7:0] e,
                           input logic [1:0] m, input logic [3:0] r);
    cif.cmd_valid  = v;
    cif.cmd_start  = s;
    cif.cmd_end    = e;
    cif.cmd_mode   = m;
    cif.cmd_repeat = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit done_seen;
    int run;
    int n;
    total = 0;
    bad   = 0;

    // One-shot 3->6, then auto-reload down 5->3 x2, ping-pong 2<->4, mode 11,
    // start==end reload x4, start==end ping-pong, IDLE ignoring hold/abort.
    add(1'b1, 8'd3, 8'd6, 2'd0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 8'd5, 8'd3, 2'd1, 4'd1, 1'b0, 1'b0, 8'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 8'd2, 8'd4, 2'd2, 4'd2, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 8'd1, 8'd2, 2'd3, 4'd5, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 8'd9, 8'd9, 2'd1, 4'd3, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 8'd7, 8'd7, 2'd2, 4'd1, 1'b0, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b1, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'd0, 8'd0, 2'd0, 4'd0, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset state.
    reset = 1'b1;
    hold  = 1'b0;
    abort = 1'b0;
    drive_cmd(1'b0, 8'd0, 8'd0, 2'd0, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_dir", dir, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", tick, 0);
    chk("rst_ready", cif.cmd_ready, 0);
    reset = 1'b0;

    // Table-driven vectors.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive_cmd(vecs[i].v, vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].r);
      hold  = vecs[i].h;
      abort = vecs[i].a;
      #1;
      chk($sformatf("vec%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("vec%0d_dir", i), dir, vecs[i].d);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].b);
      chk($sformatf("vec%0d_tick", i), tick, vecs[i].t);
      chk($sformatf("vec%0d_done", i), done, vecs[i].dn);
      chk($sformatf("vec%0d_ready", i), cif.cmd_ready, vecs[i].rdy);
    end

    // Hold for 3 cycles at count=4 of a one-shot 0->8 job.
    @(negedge clk);
    hold = 1'b0;
    abort = 1'b0;
    drive_cmd(1'b1, 8'd0, 8'd8, 2'd0, 4'd0);
    #1;
    chk("hold_accept_ready", cif.cmd_ready, 1);
    @(negedge clk);
    drive_cmd(1'b0, 8'd0, 8'd0, 2'd0, 4'd0);
    done_seen = 1'b0;
    run = 0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      hold = (i >= 4) && (i < 7);
      #1;
      if (done) begin
        done_seen = 1'b1;
        chk("hold_done_count", count, 8);
      end else if (hold) begin
        chk($sformatf("hold_freeze%0d", i), count, 4);
        chk($sformatf("hold_tick%0d", i), tick, 0);
        run++;
      end else begin
        chk($sformatf("hold_step%0d", i), count, (i < 4) ? i : i - 3);
        chk($sformatf("hold_tick%0d", i), tick, (i == 11) ? 1 : 0);
        if (busy) run++;
      end
      @(negedge clk);
    end
    hold = 1'b0;
    chk("hold_done_seen", done_seen, 1);
    chk("hold_run_cycles", run, 12);

    // Abort together with hold at count=2 of a 0->9 job.
    drive_cmd(1'b1, 8'd0, 8'd9, 2'd0, 4'd0);
    #1;
    chk("abort_accept_ready", cif.cmd_ready, 1);
    @(negedge clk);
    drive_cmd(1'b0, 8'd0, 8'd0, 2'd0, 4'd0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("abort_pre%0d", i), count, i);
      @(negedge clk);
    end
    hold  = 1'b1;
    abort = 1'b1;
    #1;
    chk("abort_at_count", count, 2);
    chk("abort_tick", tick, 0);
    @(negedge clk);
    hold  = 1'b0;
    abort = 1'b0;
    drive_cmd(1'b1, 8'd1, 8'd1, 2'd0, 4'd0);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_count", count, 2);
    chk("abort_done", done, 0);
    chk("abort_ready", cif.cmd_ready, 1);
    @(negedge clk);
    drive_cmd(1'b0, 8'd0, 8'd0, 2'd0, 4'd0);
    #1;
    chk("abort_new_count", count, 1);
    chk("abort_new_busy", busy, 1);
    chk("abort_new_tick", tick, 1);
    @(negedge clk);
    #1;
    chk("abort_new_done", done, 1);
    @(negedge clk);
    #1;
    chk("abort_new_idle", cif.cmd_ready, 1);

    // Sync reset pulse at count=7 with cmd_valid held high.
    drive_cmd(1'b1, 8'd0, 8'd9, 2'd0, 4'd0);
    @(negedge clk);
    drive_cmd(1'b0, 8'd0, 8'd0, 2'd0, 4'd0);
    for (int i = 0; i < 7; i++) begin
      #1;
      chk($sformatf("rstrun_pre%0d", i), count, i);
      @(negedge clk);
    end
    reset = 1'b1;
    drive_cmd(1'b1, 8'd4, 8'd5, 2'd0, 4'd0);
    #1;
    chk("rstrun_at_count", count, 7);
    chk("rstrun_ready_in_reset", cif.cmd_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rstrun_count", count, 0);
    chk("rstrun_busy", busy, 0);
    chk("rstrun_dir", dir, 1);
    chk("rstrun_ready", cif.cmd_ready, 1);
    @(negedge clk);
    drive_cmd(1'b0, 8'd0, 8'd0, 2'd0, 4'd0);
    #1;
    chk("rstrun_new_count", count, 4);
    chk("rstrun_new_busy", busy, 1);
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rstrun_new_done", done, 1);
    chk("rstrun_new_final", count, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Self-contained programmable up/down count engine with an FSM that sequences one counting job at a time.
A job is accepted over a valid/ready command port and specifies start value, end value, mode (one-shot, auto-reload, ping-pong) and repeat count.
The block emits a terminal tick per completed pass and a done pulse per completed job.
It is the block that schedules counting jobs for timer/sequencing logic, so callers never drive raw up/down/load controls.

Parameters:
WIDTH, 8, bit width of count, cmd_start and cmd_end (unsigned).
REP_W, 4, bit width of cmd_repeat; a job runs cmd_repeat+1 passes.

Ports:
clk  input  1  clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
cmd_valid  input  1  job request valid.
cmd_ready  output  1  high exactly when FSM is in IDLE and reset is low.
cmd_start  input  WIDTH  first count value of each pass.
cmd_end  input  WIDTH  terminal value of first pass.
cmd_mode  input  2  00 one-shot, 01 auto-reload, 10 ping-pong, 11 treated as one-shot.
cmd_repeat  input  REP_W  extra passes after the first (ignored in one-shot).
hold  input  1  freeze count and pass counter while high.
abort  input  1  cancel active job.
count  output  WIDTH  current count value (registered).
dir  output  1  1 = counting up toward target, 0 = down (registered).
busy  output  1  high when FSM is not IDLE.
tick  output  1  combinational: state==RUN && !hold && !abort && count==target.
done  output  1  one-cycle pulse, high while FSM is in DONE.

Behaviour:
- Reset (sync, checked first): state=IDLE, count=0, dir=1, internal target=0, passes_left=0. Outputs busy=0, done=0, tick=0, cmd_ready=0 during reset.
- States: IDLE, RUN, DONE. Only DONE->IDLE is unconditional.
- IDLE: on cmd_valid&&cmd_ready, latch start, end, mode and passes_left=(mode==one-shot ? 0 : cmd_repeat).
  - Same edge: count<=cmd_start, target<=cmd_end, dir<=(cmd_end>=cmd_start), go to RUN.
  - No further command is accepted until IDLE is re-entered.
- RUN, per cycle, priority abort > hold > terminal > step:
  - abort: go to IDLE; count holds; no done pulse.
  - hold: nothing changes; tick=0.
  - count!=target: count steps by 1 toward target (+1 if dir=1, else -1). Never wraps; unsigned compare over full WIDTH.
  - count==target with passes_left==0: tick=1; go to DONE; count holds.
  - count==target with passes_left>0: tick=1; passes_left decrements, then by mode:
    - auto-reload: count<=start; target unchanged.
    - ping-pong: target swaps between latched end and latched start; dir inverts; count steps one toward the new target on the same edge. If start==end, count stays.
- DONE: done=1, busy=1, cmd_ready=0; count holds. Next edge goes to IDLE, unless abort is high, which also goes to IDLE.
- IDLE: abort and hold are ignored; count holds its last value.
- start==end: every unheld RUN cycle is terminal, giving cmd_repeat+1 consecutive ticks, then DONE.
- One-shot latency: acceptance edge -> count=start next cycle; tick in the cycle count==end; done one cycle later; cmd_ready one cycle after done.
- Reset asserted in any state overrides everything, including cmd_valid and abort.

Test Plan:
1. One-shot start=3, end=6 -> count 3,4,5,6 over cycles 1-4 after acceptance; tick only at cycle 4; done at cycle 5 with count=6; cmd_ready=1 at cycle 6.
2. Auto-reload down, start=5, end=3, repeat=1 -> count 5,4,3,5,4,3; tick at both 3s; done the next cycle; dir=0 throughout.
3. Ping-pong start=2, end=4, repeat=2 -> count 2,3,4,3,2,3,4; ticks at 4, 2, 4; dir toggles after each tick; done follows the last 4.
4. Hold high for 3 cycles mid-run at count=4 (one-shot 0->8) -> count stays 4 and tick stays 0 for 3 cycles; run then resumes 5..8; total run cycles +3.
5. abort together with hold at count=2 of a 0->9 job -> IDLE next cycle, count=2, done never pulses, cmd_ready=1. A new job is accepted on the following cycle.
6. Sync reset pulse during RUN at count=7 -> next cycle count=0, busy=0, dir=1. cmd_valid held high throughout is accepted on the first cycle after reset deasserts. Also run start=end=9, mode auto-reload, repeat=3 -> 4 consecutive ticks, then done.
